// File: rtl/up_down_counter_prog_pkg.sv
// Shared encodings for the programmable up/down counter: register addresses,
// CCR bit positions, run modes and FSM states.
package up_down_counter_prog_pkg;

    localparam logic [1:0] ADDR_PLR = 2'd0;
    localparam logic [1:0] ADDR_ULR = 2'd1;
    localparam logic [1:0] ADDR_LLR = 2'd2;
    localparam logic [1:0] ADDR_CCR = 2'd3;

    localparam int CCR_DIR_BIT  = 2;
    localparam int CCR_STOP_BIT = 3;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_WRAP     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // The stop bit is a command, so it never stays in the stored CCR image.
    function automatic logic [7:0] ccr_store(input logic [7:0] wdata);
        return {wdata[7:4], 1'b0, wdata[2:0]};
    endfunction

endpackage

// File: rtl/up_down_counter_prog_if.sv
// Host strobe bus of the programmable counter (data bus stays a plain inout port).
interface up_down_counter_prog_if;
    logic ncs;
    logic nrd;
    logic nwr;
    logic a0;
    logic a1;
    logic start;

    modport master (output ncs, nrd, nwr, a0, a1, start);
    modport slave  (input  ncs, nrd, nwr, a0, a1, start);
endinterface

// File: rtl/up_down_counter_prog_prescaler.sv
// udc_prescaler: 4-bit tick divider, one tick per (div+1) enabled clocks.
// Only compiled when PRESCALE_EN is defined.
`ifdef PRESCALE_EN
module udc_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] div,
    output logic       tick
);
    logic [3:0] cnt_r;

    assign tick = en & (cnt_r == div);

    // Divider counter, restarted by clr or whenever counting is disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 4'd0;
        end else if (clr || !en) begin
            cnt_r <= 4'd0;
        end else if (tick) begin
            cnt_r <= 4'd0;
        end else begin
            cnt_r <= cnt_r + 4'd1;
        end
    end
endmodule
`endif

// File: rtl/up_down_counter_prog.sv
// Bus-programmable up/down counter with one-shot, wrap and ping-pong modes.
// Define PRESCALE_EN to make CCR[7:4] divide the counting rate.
module up_down_counter_prog
    import up_down_counter_prog_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CNT_RST = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire  [WIDTH-1:0]      din,
    up_down_counter_prog_if.slave bus,
    output logic [WIDTH-1:0]      count,
    output logic                  err,
    output logic                  ec,
    output logic                  dir
);
    logic [1:0]       addr_s;
    logic             rd_en_s;
    logic             wr_en_s;
    logic             stop_s;
    logic             start_edge_s;
    logic             cfg_ok_s;
    logic             at_limit_s;
    logic             tick_s;
    logic [WIDTH-1:0] rd_data_s;

    logic [WIDTH-1:0] plr_r;
    logic [WIDTH-1:0] ulr_r;
    logic [WIDTH-1:0] llr_r;
    logic [7:0]       ccr_r;
    logic [WIDTH-1:0] plr_a_r;
    logic [WIDTH-1:0] ulr_a_r;
    logic [WIDTH-1:0] llr_a_r;
    mode_e            mode_a_r;
    state_e           state_r;
    logic             start_q_r;

    assign addr_s       = {bus.a1, bus.a0};
    assign rd_en_s      = ~bus.ncs & ~bus.nrd & bus.nwr;
    assign wr_en_s      = ~bus.ncs & ~bus.nwr;
    assign stop_s       = wr_en_s && (addr_s == ADDR_CCR) && din[CCR_STOP_BIT];
    assign start_edge_s = bus.start & ~start_q_r;
    assign cfg_ok_s     = (llr_r < ulr_r) && (llr_r <= plr_r) && (plr_r <= ulr_r) &&
                          (mode_e'(ccr_r[1:0]) != MODE_RSVD);
    assign at_limit_s   = dir ? (count == ulr_a_r) : (count == llr_a_r);

`ifdef PRESCALE_EN
    logic [3:0] presc_a_r;
    logic       presc_clr_s;

    assign presc_clr_s = (state_r != ST_RUN) | stop_s | start_edge_s;

    udc_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (state_r == ST_RUN),
        .clr   (presc_clr_s),
        .div   (presc_a_r),
        .tick  (tick_s)
    );

    // Prescale setting is frozen for the run at the accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_a_r <= 4'd0;
        end else if (!stop_s && start_edge_s && cfg_ok_s) begin
            presc_a_r <= ccr_r[7:4];
        end else begin
            presc_a_r <= presc_a_r;
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    // Read mux: address 0 returns the live count rather than PLR.
    always_comb begin
        rd_data_s = '0;
        case (addr_s)
            ADDR_PLR: rd_data_s = count;
            ADDR_ULR: rd_data_s = ulr_r;
            ADDR_LLR: rd_data_s = llr_r;
            ADDR_CCR: rd_data_s = WIDTH'(ccr_r);
            default:  rd_data_s = '0;
        endcase
    end

    assign din = rd_en_s ? rd_data_s : {WIDTH{1'bz}};

    // Shadow registers accept host writes at any time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plr_r <= '0;
            ulr_r <= '0;
            llr_r <= '0;
            ccr_r <= 8'd0;
        end else if (wr_en_s) begin
            case (addr_s)
                ADDR_PLR: plr_r <= din;
                ADDR_ULR: ulr_r <= din;
                ADDR_LLR: llr_r <= din;
                ADDR_CCR: ccr_r <= ccr_store(din[7:0]);
                default:  ccr_r <= ccr_r;
            endcase
        end else begin
            ccr_r <= ccr_r;
        end
    end

    // Run FSM and count datapath; stop outranks start, start outranks counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            start_q_r <= 1'b0;
            count     <= CNT_RST;
            err       <= 1'b0;
            ec        <= 1'b0;
            dir       <= 1'b0;
            plr_a_r   <= '0;
            ulr_a_r   <= '0;
            llr_a_r   <= '0;
            mode_a_r  <= MODE_ONESHOT;
        end else begin
            start_q_r <= bus.start;
            ec        <= 1'b0;
            if (stop_s) begin
                state_r <= ST_IDLE;
            end else if (start_edge_s) begin
                if (cfg_ok_s) begin
                    state_r  <= ST_RUN;
                    count    <= plr_r;
                    dir      <= ccr_r[CCR_DIR_BIT];
                    err      <= 1'b0;
                    plr_a_r  <= plr_r;
                    ulr_a_r  <= ulr_r;
                    llr_a_r  <= llr_r;
                    mode_a_r <= mode_e'(ccr_r[1:0]);
                end else begin
                    state_r <= ST_IDLE;
                    err     <= 1'b1;
                end
            end else if ((state_r == ST_RUN) && tick_s) begin
                if (at_limit_s) begin
                    ec <= 1'b1;
                    case (mode_a_r)
                        MODE_WRAP: count <= plr_a_r;
                        MODE_PINGPONG: begin
                            dir   <= ~dir;
                            count <= dir ? (count - WIDTH'(1)) : (count + WIDTH'(1));
                        end
                        default: state_r <= ST_IDLE;
                    endcase
                end else begin
                    count <= dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule
